// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs decoded RV32I fields into instruction words and streams them into IMEM
// Range/alignment checks mirror ImmGen so that each word decodes back to the supplied immediate.
module instr_encoder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  input  logic                  last,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t             state;
  state_t             state_nx;
  logic               accept;
  logic               legal;
  logic               last_addr;
  logic [1:0]         chk_code;
  logic [31:0]        word;
  logic signed [31:0] imm_s;

  assign imm_s     = imm;
  assign in_ready  = (state == LOAD);
  assign done      = (state == FULL);
  assign accept    = in_valid && in_ready && !start;
  assign legal     = (chk_code == 2'd0);
  assign last_addr = (count[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});

  // Field packing and immediate legality for the beat currently presented.
  always_comb begin
    word     = 32'h0;
    chk_code = 2'd0;
    case (fmt)
      3'd0: word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        if (imm_s < -32'sd2048 || imm_s > 32'sd2047) chk_code = 2'd1;
      end
      3'd2: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (imm_s < -32'sd2048 || imm_s > 32'sd2047) chk_code = 2'd1;
      end
      3'd3: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (imm_s < -32'sd4096 || imm_s > 32'sd4094) chk_code = 2'd1;
        else if (imm[0])                             chk_code = 2'd2;
      end
      3'd4: begin
        word = {imm[31:12], rd, opcode};
        if (imm[11:0] != 12'h000) chk_code = 2'd1;
      end
      3'd5: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (imm_s < -32'sd1048576 || imm_s > 32'sd1048574) chk_code = 2'd1;
        else if (imm[0])                                   chk_code = 2'd2;
      end
      default: chk_code = 2'd3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // An illegal final beat still ends the session; a legal one also ends it on the last address.
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = LOAD;
    end else if (accept) begin
      if (last || (legal && last_addr)) state_nx = FULL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 32'h0;
      count    <= '0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        count    <= '0;
        err      <= 1'b0;
        err_code <= 2'd0;
      end else if (accept) begin
        if (legal) begin
          wr_en   <= 1'b1;
          wr_addr <= count[ADDR_WIDTH-1:0];
          wr_data <= word;
          count   <= count + CNT_ONE;
        end else begin
          err <= 1'b1;
          if (!err) err_code <= chk_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed and randomized bench for instr_encoder
// Expected words come from an arithmetic field-placement model of the RV32I formats.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        last;

  logic        in_ready, wr_en, done, err;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [8:0]  count;
  logic [1:0]  err_code;

  logic        in_ready2, wr_en2, done2, err2;
  logic [1:0]  wr_addr2;
  logic [31:0] wr_data2;
  logic [2:0]  count2;
  logic [1:0]  err_code2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .last(last), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .count(count), .done(done), .err(err), .err_code(err_code)
  );

  instr_encoder #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .last(last), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .count(count2), .done(done2), .err(err2), .err_code(err_code2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] im, input logic l);
    in_valid = 1'b1;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im; last = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference: legality by signed value range, word by shifting fields into their bit positions.
  function automatic void model(input int f, input logic [6:0] op, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] im,
                                output logic [1:0] code, output logic [31:0] w);
    longint v;
    logic [31:0] base;
    v    = longint'($signed(im));
    base = 32'(op) + (32'(d) << 7) + (32'(f3) << 12) + (32'(s1) << 15);
    code = 2'd0;
    w    = 32'h0;
    case (f)
      0: w = base + (32'(s2) << 20) + (32'(f7) << 25);
      1: begin
        if (v < -2048 || v > 2047) code = 2'd1;
        w = base + ((im & 32'hFFF) << 20);
      end
      2: begin
        if (v < -2048 || v > 2047) code = 2'd1;
        w = 32'(op) + (32'(f3) << 12) + (32'(s1) << 15) + (32'(s2) << 20)
          + (((im >> 5) & 32'h7F) << 25) + ((im & 32'h1F) << 7);
      end
      3: begin
        if (v < -4096 || v > 4094) code = 2'd1;
        else if (v % 2 != 0)       code = 2'd2;
        w = 32'(op) + (32'(f3) << 12) + (32'(s1) << 15) + (32'(s2) << 20)
          + (((im >> 12) & 32'h1) << 31) + (((im >> 5) & 32'h3F) << 25)
          + (((im >> 1) & 32'hF) << 8) + (((im >> 11) & 32'h1) << 7);
      end
      4: begin
        if ((im & 32'hFFF) != 0) code = 2'd1;
        w = 32'(op) + (32'(d) << 7) + (im & 32'hFFFFF000);
      end
      5: begin
        if (v < -1048576 || v > 1048574) code = 2'd1;
        else if (v % 2 != 0)             code = 2'd2;
        w = 32'(op) + (32'(d) << 7) + (((im >> 20) & 32'h1) << 31)
          + (((im >> 1) & 32'h3FF) << 21) + (((im >> 11) & 32'h1) << 20)
          + (((im >> 12) & 32'hFF) << 12);
      end
      default: code = 2'd3;
    endcase
  endfunction

  logic [31:0] exp_w;
  logic [1:0]  exp_c;
  logic [1:0]  m_code;
  logic        m_err;
  int          m_ptr;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0;
    fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'h0;
    tick(); tick();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    pulse_start();
    chk("load_in_ready", 32'(in_ready), 32'd1);
    set_beat(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd5, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("addi_wr_en", 32'(wr_en), 32'd1);
    chk("addi_addr", 32'(wr_addr), 32'd0);
    chk("addi_data", wr_data, 32'hFFB00093);
    chk("addi_count", 32'(count), 32'd1);
    tick();
    chk("idle_wr_en", 32'(wr_en), 32'd0);

    pulse_start();
    set_beat(3'd2, 7'h23, 5'd0, 5'd1, 5'd5, 3'd2, 7'd0, -32'sd16, 1'b0);
    tick();
    chk("s_data", wr_data, 32'hFE50A823);
    chk("s_addr", 32'(wr_addr), 32'd0);
    set_beat(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0);
    tick();
    chk("b_data", wr_data, 32'h00208463);
    chk("b_addr", 32'(wr_addr), 32'd1);
    set_beat(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd20, 1'b0);
    tick();
    chk("j_data", wr_data, 32'h014000EF);
    chk("j_wr_en", 32'(wr_en), 32'd1);
    set_beat(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("u_data", wr_data, 32'h123452B7);
    chk("u_addr", 32'(wr_addr), 32'd3);
    chk("u_done", 32'(done), 32'd1);
    chk("u_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("done_hold", 32'(done), 32'd1);

    pulse_start();
    set_beat(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
    tick();
    chk("irange_wr_en", 32'(wr_en), 32'd0);
    chk("irange_err", 32'(err), 32'd1);
    set_beat(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 1'b0);
    tick();
    chk("bodd_wr_en", 32'(wr_en), 32'd0);
    chk("first_code", 32'(err_code), 32'd1);
    set_beat(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("r_data", wr_data, 32'h002081B3);
    chk("r_addr", 32'(wr_addr), 32'd0);

    pulse_start();
    set_beat(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("ill_wr_en", 32'(wr_en), 32'd0);
    chk("ill_code", 32'(err_code), 32'd3);
    chk("ill_done", 32'(done), 32'd1);
    pulse_start();
    chk("restart_err", 32'(err), 32'd0);
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_in_ready", 32'(in_ready), 32'd1);

    pulse_start();
    m_ptr = 0; m_err = 1'b0; m_code = 2'd0;
    for (int i = 0; i < 40; i++) begin
      int f;
      logic [31:0] r_imm;
      f = int'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: r_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: r_imm = $urandom;
        2: r_imm = $urandom & 32'hFFFFF000;
        default: r_imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      endcase
      set_beat(3'(f), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               3'($urandom), 7'($urandom), r_imm, 1'b0);
      model(f, opcode, rd, rs1, rs2, funct3, funct7, imm, exp_c, exp_w);
      tick();
      if (exp_c == 2'd0) begin
        chk("rnd_wr_en", 32'(wr_en), 32'd1);
        chk("rnd_addr", 32'(wr_addr), 32'(m_ptr));
        chk("rnd_data", wr_data, exp_w);
        m_ptr++;
      end else begin
        chk("rnd_no_write", 32'(wr_en), 32'd0);
        if (!m_err) m_code = exp_c;
        m_err = 1'b1;
      end
      chk("rnd_err", 32'(err), 32'(m_err));
      chk("rnd_err_code", 32'(err_code), 32'(m_code));
    end
    in_valid = 1'b0;
    chk("rnd_count", 32'(count), 32'(m_ptr));

    pulse_start();
    set_beat(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) begin
        chk("fill_wr_en", 32'(wr_en2), 32'd1);
        chk("fill_addr", 32'(wr_addr2), 32'(i));
      end else begin
        chk("fill_fifth_wr_en", 32'(wr_en2), 32'd0);
      end
      if (i == 3) begin
        chk("fill_done", 32'(done2), 32'd1);
        chk("fill_in_ready", 32'(in_ready2), 32'd0);
      end
    end
    in_valid = 1'b0;
    chk("fill_count", 32'(count2), 32'd4);

    start = 1'b1;
    set_beat(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
    tick();
    start = 1'b0;
    chk("prio_wr_en", 32'(wr_en), 32'd0);
    chk("prio_count", 32'(count), 32'd0);
    tick();
    chk("prio_addr", 32'(wr_addr), 32'd0);
    chk("prio_wr_en2", 32'(wr_en), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("pend_wr_en", 32'(wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_wr_data", wr_data, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
